// File: rtl/sub_chain_arb.sv
// sub_chain_arb: round-robin issue of two requesters into the sub chain,
// tagged results into a credit-limited FIFO; SUB_CHAIN_ARB_STATS_EN adds grant counters.
module sub_chain_arb #(
  parameter int DW      = 8,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_data,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_data,
  output logic [DW-1:0] dp_data_in,
  input  logic [DW-1:0] dp_data_out,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_id
`ifdef SUB_CHAIN_ARB_STATS_EN
  ,
  output logic [15:0]   grant_cnt0,
  output logic [15:0]   grant_cnt1
`endif
);

  localparam int OW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [OW-1:0] OCC_MAX = OW'(DEPTH);
  localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH - 1);

  typedef struct packed {
    logic v;
    logic id;
  } tag_t;

  logic [OW-1:0]    occ;
  logic             last;
  logic             any_valid;
  logic             issue_ok;
  logic             issue;
  logic             winner;
  logic             pop;
  logic             wr;
  logic [DW-1:0]    win_data;
  tag_t             tag_in;
  tag_t [LATENCY:1] tag_q;
  logic [DW-1:0]    mem_data [DEPTH];
  logic             mem_id   [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic [OW-1:0]    cnt;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    winner = 1'b0;
    unique case (1'b1)
      (req0_valid && !req1_valid): winner = 1'b0;
      (!req0_valid && req1_valid): winner = 1'b1;
      (req0_valid && req1_valid):  winner = ~last;
      default:                     winner = 1'b0;
    endcase
  end

  // Credits come from the registered occ, so a same-cycle pop frees nothing yet.
  assign any_valid  = req0_valid | req1_valid;
  assign issue_ok   = !rst && (occ < OCC_MAX);
  assign issue      = issue_ok && any_valid;
  assign req0_ready = issue_ok && req0_valid && !winner;
  assign req1_ready = issue_ok && req1_valid && winner;
  assign win_data   = winner ? req1_data : req0_data;

  assign tag_in.v  = issue;
  assign tag_in.id = winner;

  assign wr        = tag_q[LATENCY].v;
  assign rsp_valid = (cnt != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_data  = rsp_valid ? mem_data[rp] : '0;
  assign rsp_id    = rsp_valid ? mem_id[rp] : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last       <= 1'b1;
      dp_data_in <= '0;
    end else begin
      if (issue) begin
        last <= winner;
      end
      dp_data_in <= issue ? win_data : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ <= '0;
    end else begin
      unique case ({issue, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Tag travels alongside the word; it reaches the end as the word leaves the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q <= '0;
    end else begin
      tag_q[1] <= tag_in;
      for (int i = 2; i <= LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_id[i]   <= 1'b0;
      end
    end else begin
      if (wr) begin
        mem_data[wp] <= dp_data_out;
        mem_id[wp]   <= tag_q[LATENCY].id;
        wp           <= ptr_inc(wp);
      end
      if (pop) begin
        rp <= ptr_inc(rp);
      end
      unique case ({wr, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef SUB_CHAIN_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (issue && !winner && grant_cnt0 != 16'hFFFF) begin
        grant_cnt0 <= grant_cnt0 + 1'b1;
      end
      if (issue && winner && grant_cnt1 != 16'hFFFF) begin
        grant_cnt1 <= grant_cnt1 + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sub_chain_arb.sv
// tb_sub_chain_arb: vector table, directed corner sequences and a
// randomized run against a queue-based model of sub_chain_arb.
module tb_sub_chain_arb;

  localparam int DW      = 8;
  localparam int LATENCY = 2;
  localparam int DEPTH   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0;
  logic          req0_ready;
  logic [DW-1:0] req0_data = '0;
  logic          req1_valid = 1'b0;
  logic          req1_ready;
  logic [DW-1:0] req1_data = '0;
  logic [DW-1:0] dp_data_in;
  logic [DW-1:0] dp_data_out;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic          rsp_id;
`ifdef SUB_CHAIN_ARB_STATS_EN
  logic [15:0]   grant_cnt0;
  logic [15:0]   grant_cnt1;
`endif

  int errors = 0;
  int checks = 0;

  sub_chain_arb #(
    .DW(DW),
    .LATENCY(LATENCY),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_data(req0_data),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_data(req1_data),
    .dp_data_in(dp_data_in),
    .dp_data_out(dp_data_out),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .rsp_id(rsp_id)
`ifdef SUB_CHAIN_ARB_STATS_EN
    ,
    .grant_cnt0(grant_cnt0),
    .grant_cnt1(grant_cnt1)
`endif
  );

  always #5 clk = ~clk;

  // Chain model: output lags the issue by LATENCY cycles, the first
  // of which is the arbiter's own dp_data_in register.
  logic [DW-1:0] chain [LATENCY-1];
  always @(posedge clk) begin
    chain[0] <= dp_data_in;
    for (int i = 1; i < LATENCY - 1; i++) chain[i] <= chain[i-1];
  end
  assign dp_data_out = chain[LATENCY-2];

  typedef struct {
    logic       v0;
    logic       v1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       r0;
    logic       r1;
  } vec_t;

  typedef struct {
    logic       id;
    logic [7:0] data;
    int         avail;
  } exp_t;

  vec_t vt[10];
  exp_t q[$];
  logic [8:0] got[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = '0;
    req1_data  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    rsp_ready = 1'b0;
    #12;
    rst = 1'b0;
    tick();
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, "_dp"}, dp_data_in, 0);
    chk({nm, "_rv"}, rsp_valid, 0);
    chk({nm, "_rd"}, rsp_data, 0);
    chk({nm, "_ri"}, rsp_id, 0);
    chk({nm, "_r0"}, req0_ready, 0);
    chk({nm, "_r1"}, req1_ready, 0);
  endtask

  initial begin
    int acc;
    logic m_last;
    logic v0, v1, ok, w, ev;
    logic [7:0] d0, d1;
    int cyc;

    vt[0] = '{1'b1, 1'b1, 8'h01, 8'h81, 1'b1, 1'b0};
    vt[1] = '{1'b1, 1'b1, 8'h02, 8'h82, 1'b0, 1'b1};
    vt[2] = '{1'b0, 1'b1, 8'h03, 8'h83, 1'b0, 1'b1};
    vt[3] = '{1'b1, 1'b1, 8'h04, 8'h84, 1'b1, 1'b0};
    vt[4] = '{1'b1, 1'b0, 8'h05, 8'h85, 1'b1, 1'b0};
    vt[5] = '{1'b1, 1'b1, 8'h06, 8'h86, 1'b0, 1'b1};
    vt[6] = '{1'b0, 1'b0, 8'h07, 8'h87, 1'b0, 1'b0};
    vt[7] = '{1'b1, 1'b1, 8'h08, 8'h88, 1'b1, 1'b0};
    vt[8] = '{1'b0, 1'b1, 8'h09, 8'h89, 1'b0, 1'b1};
    vt[9] = '{1'b1, 1'b0, 8'h0A, 8'h8A, 1'b1, 1'b0};

    // Reset held from time 0 with both requesters asking.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #3;
    chk_zero_outputs("rst0");

    // Arbitration table, responses drained freely.
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req0_valid = vt[i].v0;
      req1_valid = vt[i].v1;
      req0_data  = vt[i].d0;
      req1_data  = vt[i].d1;
      #1;
      chk("tbl_r0", req0_ready, vt[i].r0);
      chk("tbl_r1", req1_ready, vt[i].r1);
      tick();
      chk("tbl_dp", dp_data_in,
          vt[i].r0 ? vt[i].d0 : (vt[i].r1 ? vt[i].d1 : 8'h00));
    end

    // Single word: response exactly three cycles after issue, one cycle wide.
    do_reset();
    rsp_ready  = 1'b1;
    req0_valid = 1'b1;
    req0_data  = 8'h3C;
    #1;
    chk("one_r0", req0_ready, 1);
    tick();
    idle_inputs();
    #1;
    chk("one_dp", dp_data_in, 8'h3C);
    chk("one_c1", rsp_valid, 0);
    tick();
    chk("one_c2", rsp_valid, 0);
    chk("one_dp0", dp_data_in, 0);
    tick();
    chk("one_c3", rsp_valid, 1);
    chk("one_data", rsp_data, 8'h3C);
    chk("one_id", rsp_id, 0);
    tick();
    chk("one_c4", rsp_valid, 0);

    // Contention: alternating grants, responses in issue order.
    do_reset();
    rsp_ready = 1'b1;
    got.delete();
    for (int n = 0; n < 8; n++) begin
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      req0_data  = 8'(8'h10 + n);
      req1_data  = 8'(8'h20 + n);
      #1;
      chk("cont_r0", req0_ready, (n % 2) == 0);
      chk("cont_r1", req1_ready, (n % 2) == 1);
      if (rsp_valid) got.push_back({rsp_id, rsp_data});
      tick();
    end
    idle_inputs();
    for (int n = 0; n < 8; n++) begin
      #1;
      if (rsp_valid) got.push_back({rsp_id, rsp_data});
      tick();
    end
    chk("cont_cnt", got.size(), 8);
    for (int n = 0; n < 8 && n < got.size(); n++) begin
      if (n % 2 == 0) chk("cont_rsp", got[n], {1'b0, 8'(8'h10 + n)});
      else            chk("cont_rsp", got[n], {1'b1, 8'(8'h20 + n)});
    end
`ifdef SUB_CHAIN_ARB_STATS_EN
    chk("stats_g0", grant_cnt0, 16'd4);
    chk("stats_g1", grant_cnt1, 16'd4);
`endif

    // Backpressure: credits run out at DEPTH, one pop frees one slot.
    do_reset();
    rsp_ready  = 1'b0;
    req0_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      req0_data = 8'(8'h40 + i);
      #1;
      if (req0_ready) acc++;
      tick();
    end
    chk("bp_acc", acc, DEPTH);
    #1;
    chk("bp_full", req0_ready, 0);
    chk("bp_head_v", rsp_valid, 1);
    chk("bp_head", rsp_data, 8'h40);
    rsp_ready = 1'b1;
    #1;
    chk("bp_popcyc", req0_ready, 0);
    tick();
    rsp_ready = 1'b0;
    #1;
    chk("bp_admit", req0_ready, 1);
    chk("bp_head2", rsp_data, 8'h41);
    tick();
    chk("bp_refull", req0_ready, 0);

    // Reset with words in flight: nothing survives, state restarts.
    do_reset();
    rsp_ready  = 1'b0;
    req0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req0_data = 8'(8'h60 + i);
      tick();
    end
    req1_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk_zero_outputs("rstmid");
    #10;
    idle_inputs();
    rst = 1'b0;
    tick();
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rstf_rv", rsp_valid, 0);
      tick();
    end
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      chk("rstf_r0", req0_ready, i < 4 && (i % 2) == 0);
      chk("rstf_r1", req1_ready, i < 4 && (i % 2) == 1);
      tick();
    end

    // Randomized run against the queue model.
    do_reset();
    q.delete();
    m_last = 1'b1;
    cyc = 0;
    for (int k = 0; k < 400; k++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      req0_valid = v0;
      req1_valid = v1;
      req0_data  = d0;
      req1_data  = d1;
      rsp_ready  = ($urandom_range(0, 3) != 0);
      #1;
      ok = (v0 || v1) && (q.size() < DEPTH);
      w  = (v0 && v1) ? ~m_last : v1;
      chk("rnd_r0", req0_ready, ok && !w);
      chk("rnd_r1", req1_ready, ok && w);
      ev = (q.size() > 0) && (q[0].avail <= cyc);
      chk("rnd_rv", rsp_valid, ev);
      if (ev) begin
        chk("rnd_rd", rsp_data, q[0].data);
        chk("rnd_ri", rsp_id, q[0].id);
        if (rsp_ready) void'(q.pop_front());
      end
      if (ok) begin
        q.push_back('{w, w ? d1 : d0, cyc + LATENCY + 1});
        m_last = w;
      end
      tick();
      cyc++;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
